// File: rtl/mux_tree_pipe.sv
// -----------------------------------------------------------------------------
// mux_tree_pipe
//   Pipelined N:1 multiplexer. The selection is a binary tree of 2:1 stages,
//   with one register level between tree levels. Latency is LEVELS cycles
//   when the pipe is not stalled. Used to pick one lane out of NUM_INPUTS in
//   the destination clock domain of the synchronizer datapath.
//
// Ports
//   clk        in   single clock, all state on posedge
//   rst_n      in   synchronous reset, active-low
//   in_data    in   NUM_INPUTS lanes, lane i = in_data[i*DATA_WIDTH +: DATA_WIDTH]
//   in_sel     in   lane index to forward (full range, no out-of-range case)
//   in_valid   in   in_data/in_sel valid this cycle
//   in_ready   out  block accepts input this cycle
//   out_data   out  selected lane
//   out_valid  out  out_data valid
//   out_ready  in   consumer accepts out_data
//
// Handshake: a transfer happens on a posedge where valid & ready are both 1.
//   The pipe advances as a whole when advance = ~out_valid | out_ready; when
//   advance is 0 every stage holds, so in_ready = advance and a source seeing
//   in_ready = 0 must keep in_valid/in_data/in_sel stable. out_data stays
//   stable while out_valid & ~out_ready.
//
// Storage layout
//   r_tree : all stage outputs packed back to back. Stage k produces
//            NUM_INPUTS >> (k+1) lanes starting at lane data_off(k).
//   r_selc : select bits still needed downstream. Stage k stores
//            in_sel[SEL_W-1:k+1] (SEL_W-1-k bits) at bit selc_off(k), so
//            bit selc_off(k) is the select bit consumed by stage k+1.
//   r_valid: one valid bit per stage.
// -----------------------------------------------------------------------------
module mux_tree_pipe #(
    parameter int NUM_INPUTS = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [$clog2(NUM_INPUTS)-1:0]    in_sel,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int SEL_W     = $clog2(NUM_INPUTS);
    localparam int LEVELS    = $clog2(NUM_INPUTS);
    localparam int TREE_W    = (NUM_INPUTS - 1) * DATA_WIDTH;
    localparam int SELC_BITS = (SEL_W * (SEL_W - 1)) / 2;
    // Keep the carry vector legal when there is nothing to carry (2 lanes).
    localparam int SELC_W    = (SELC_BITS > 0) ? SELC_BITS : 1;

    // First output lane of stage k inside r_tree.
    function automatic int data_off(input int k);
        return NUM_INPUTS - (NUM_INPUTS >> k);
    endfunction

    // First carried select bit of stage k inside r_selc.
    function automatic int selc_off(input int k);
        return k * (SEL_W - 1) - (k * (k - 1)) / 2;
    endfunction

    logic [TREE_W-1:0] r_tree;
    logic [SELC_W-1:0] r_selc;
    logic [LEVELS-1:0] r_valid;

    logic [TREE_W-1:0] w_tree_nxt;
    logic [SELC_W-1:0] w_selc_nxt;
    logic [LEVELS-1:0] w_valid_nxt;
    logic              w_advance;

    assign w_advance = ~r_valid[LEVELS-1] | out_ready;

    always_comb begin
        w_tree_nxt  = '0;
        w_selc_nxt  = '0;
        w_valid_nxt = '0;

        // Stage 0 works straight off the input lanes and in_sel[0].
        for (int j = 0; j < NUM_INPUTS / 2; j++) begin
            w_tree_nxt[j*DATA_WIDTH +: DATA_WIDTH] = in_sel[0]
                ? in_data[(2*j+1)*DATA_WIDTH +: DATA_WIDTH]
                : in_data[(2*j)*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int b = 0; b < SEL_W - 1; b++) begin
            w_selc_nxt[b] = in_sel[b+1];
        end
        w_valid_nxt[0] = in_valid;

        // Later stages read the previous stage's registers. The lowest
        // carried bit of stage k-1 is this stage's select; the rest moves on.
        for (int k = 1; k < LEVELS; k++) begin
            for (int j = 0; j < (NUM_INPUTS >> (k+1)); j++) begin
                w_tree_nxt[(data_off(k)+j)*DATA_WIDTH +: DATA_WIDTH] =
                    r_selc[selc_off(k-1)]
                    ? r_tree[(data_off(k-1)+2*j+1)*DATA_WIDTH +: DATA_WIDTH]
                    : r_tree[(data_off(k-1)+2*j)*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int b = 0; b < SEL_W - 1 - k; b++) begin
                w_selc_nxt[selc_off(k)+b] = r_selc[selc_off(k-1)+1+b];
            end
            w_valid_nxt[k] = r_valid[k-1];
        end
    end

    // Data and selects load on every advance regardless of valid, so bubbles
    // carry don't-care data; only the valid bits give it meaning.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tree  <= '0;
            r_selc  <= '0;
            r_valid <= '0;
        end else if (w_advance) begin
            r_tree  <= w_tree_nxt;
            r_selc  <= w_selc_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign in_ready  = w_advance;
    assign out_valid = r_valid[LEVELS-1];
    assign out_data  = r_tree[(NUM_INPUTS-2)*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_tree_pipe
//   Directed bench for mux_tree_pipe with NUM_INPUTS=16, DATA_WIDTH=8 and
//   lane i = 8'h10+i. Inputs change 1 ns after the rising edge and outputs
//   are sampled at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_mux_tree_pipe;

    localparam int NI = 16;
    localparam int DW = 8;
    localparam int SW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NI*DW-1:0] in_data;
    logic [SW-1:0]    in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;

    int n_cmp = 0;
    int n_err = 0;

    mux_tree_pipe #(
        .NUM_INPUTS (NI),
        .DATA_WIDTH (DW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [7:0] d, input bit chk_d);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'(v));
        if (chk_d) check_eq({tag, ".data"}, 32'(out_data), 32'(d));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [SW-1:0] s);
        in_valid = v;
        in_sel   = s;
    endtask

    task automatic flush(input int n);
        drive(1'b0, '0);
        repeat (n) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < NI; i++) in_data[i*DW +: DW] = 8'(8'h10 + i);
        out_ready = 1'b1;
        rst_n     = 1'b0;
        drive(1'b1, 4'd5);

        // Reset with input offered: nothing captured.
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("rst_hold%0d", i), 1'b0, 8'h00, 1'b1);
        end
        #1;
        rst_n = 1'b1;
        drive(1'b0, 4'd5);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out($sformatf("rst_after%0d", i), 1'b0, 8'h00, i < 3);
        end
        flush(4);

        // Single item, lane 5, visible for exactly one cycle after 4 edges.
        drive(1'b1, 4'd5);
        for (int c = 0; c < 6; c++) begin
            tick();
            drive(1'b0, 4'd0);
            if (c == 3) expect_out($sformatf("single%0d", c), 1'b1, 8'h15, 1'b1);
            else        expect_out($sformatf("single%0d", c), 1'b0, 8'h00, 1'b0);
        end
        flush(4);

        // Streaming all lanes back to back.
        for (int c = 0; c < 20; c++) begin
            drive(c < 16, 4'(c));
            tick();
            if (c >= 3 && c <= 18)
                expect_out($sformatf("stream%0d", c), 1'b1, 8'(8'h10 + c - 3), 1'b1);
            else
                expect_out($sformatf("stream%0d", c), 1'b0, 8'h00, 1'b0);
        end
        flush(4);

        // Backpressure: 3, 7, 12 then a 3-cycle stall on the first output.
        drive(1'b1, 4'd3);  tick();
        drive(1'b1, 4'd7);  tick();
        drive(1'b1, 4'd12); tick();
        drive(1'b0, 4'd0);  tick();
        expect_out("bp_first", 1'b1, 8'h13, 1'b1);
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            check_eq($sformatf("bp_in_ready%0d", s), 32'(in_ready), 32'd0);
            tick();
            expect_out($sformatf("bp_hold%0d", s), 1'b1, 8'h13, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_in_ready_release", 32'(in_ready), 32'd1);
        expect_out("bp_release", 1'b1, 8'h13, 1'b1);
        tick(); expect_out("bp_second", 1'b1, 8'h17, 1'b1);
        tick(); expect_out("bp_third", 1'b1, 8'h1C, 1'b1);
        tick(); expect_out("bp_empty", 1'b0, 8'h00, 1'b0);
        flush(4);

        // Boundary lanes with a bubble between them.
        drive(1'b1, 4'd15); tick();
        expect_out("bnd0", 1'b0, 8'h00, 1'b0);
        drive(1'b0, 4'd0);  tick();
        expect_out("bnd1", 1'b0, 8'h00, 1'b0);
        drive(1'b1, 4'd0);  tick();
        expect_out("bnd2", 1'b0, 8'h00, 1'b0);
        drive(1'b0, 4'd0);  tick();
        expect_out("bnd_top", 1'b1, 8'h1F, 1'b1);
        tick(); expect_out("bnd_bubble", 1'b0, 8'h00, 1'b0);
        tick(); expect_out("bnd_low", 1'b1, 8'h10, 1'b1);
        tick(); expect_out("bnd_end", 1'b0, 8'h00, 1'b0);
        flush(4);

        // Mid-flight reset drops everything in the pipe.
        drive(1'b1, 4'd1); tick();
        drive(1'b1, 4'd2); tick();
        drive(1'b1, 4'd3); tick();
        drive(1'b0, 4'd0);
        rst_n = 1'b0;
        tick();
        expect_out("mid_rst", 1'b0, 8'h00, 1'b1);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            expect_out($sformatf("mid_drop%0d", c), 1'b0, 8'h00, 1'b0);
        end
        drive(1'b1, 4'd10);
        for (int c = 0; c < 6; c++) begin
            tick();
            drive(1'b0, 4'd0);
            if (c == 3) expect_out($sformatf("mid_next%0d", c), 1'b1, 8'h1A, 1'b1);
            else        expect_out($sformatf("mid_next%0d", c), 1'b0, 8'h00, 1'b0);
        end

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
